mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MEM stage of the 32-bit five-stage pipeline. It consumes the EX/MEM register outputs and performs the data-memory load or store. A parameterised access latency is covered by a stall handshake. The stage resolves the branch (PCSrc), holds the MEM/WB pipeline register, and drives the RegWrite/Write_Register pair that the forwarding unit consumes.

Parameters:
DEPTH, 256, data-memory size in 32-bit words (power of two)
MEM_LAT, 1, data-memory access latency in cycles (>=1)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  reset, asynchronous, active-high
Mem_WB  in  2  WB control from EX/MEM; [1]=RegWrite, [0]=MemtoReg
read_En  in  1  load request
write_En  in  1  store request
Mem_Br  in  1  branch instruction in MEM
Zero  in  1  ALU zero flag
DataAddress  in  32  ALU result / byte address
WriteData  in  32  store data
dest  in  5  destination register
PCSrc  out  1  branch taken
mem_stall  out  1  freeze IF/ID/EX and EX/MEM while high
WB_ctrl  out  2  registered Mem_WB
ReadData  out  32  registered load data
ALUResult  out  32  registered DataAddress
Write_Register  out  5  registered dest
RegWrite  out  1  equals WB_ctrl[1]
misalign  out  1  registered pulse: access with DataAddress[1:0]!=0

Behaviour:
- Reset: clk and rst are the only timing inputs; rst is asynchronous, active-high. While rst is high, every registered output is 0, mem_stall is forced to 0 and the FSM is IDLE. Memory contents are not cleared.
- Word index: DataAddress[log2(DEPTH)+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH.
- Access: an access is read_En|write_En. If both are high, the cycle is a store; ReadData loads 0 for it.
- Misaligned access: DataAddress[1:0] is ignored for indexing. misalign is high for 1 cycle, in the cycle after completion.
- PCSrc = Mem_Br & Zero, combinational. It is never gated by the stall, because a branch carries no memory access.
- MEM_LAT=1: no stall. A store writes the array at the clock edge ending the cycle. A load reads the array asynchronously and ReadData captures it at the same edge. Latency to MEM/WB is 1 cycle.
- MEM_LAT=N>1, FSM IDLE/BUSY with a counter cnt (width clog2(N)):
  - IDLE + access: mem_stall=1 combinationally, go BUSY, cnt=1.
  - BUSY: mem_stall=1 while cnt<N-1, and cnt increments each cycle.
  - Completion: at cnt==N-1, mem_stall=0. The store commits and the load data is captured at that edge. Go IDLE.
  - Total stall is N-1 cycles; the instruction completes N cycles after first presentation.
- Upstream holds all EX/MEM inputs stable while mem_stall=1. Changes during stall are undefined and must be flagged by bench assertions.
- MEM/WB register while mem_stall=1: loads a bubble (WB_ctrl=0, Write_Register=0, ReadData and ALUResult unchanged). The memory op is not duplicated.
- MEM/WB register when not stalled: loads Mem_WB, DataAddress, dest and the load data every cycle.
- Non-memory instructions pass in 1 cycle regardless of MEM_LAT.
- Reset mid-BUSY: the pending store is discarded (array unchanged), FSM returns to IDLE, outputs clear.
- Back-to-back accesses: a new access presented in the cycle after completion starts a new BUSY sequence immediately.

Decomposition:
- Shared package mips_pkg:
  - Data-width constant DW=32 and register-address width RW=5.
  - WB control bit positions WB_REGWRITE=1, WB_MEMTOREG=0.
  - FSM state enum {IDLE, BUSY}.
- One sub-module, data_mem: DEPTH×32 array with a synchronous write port and an asynchronous read port.
- mem_stage holds the FSM, counter, branch logic and MEM/WB register.

Test Plan:
- MEM_LAT=1: store 0xDEADBEEF to address 0x10, then load 0x10 with Mem_WB=2'b11, dest=5 -> next cycle ReadData=0xDEADBEEF, Write_Register=5, RegWrite=1, mem_stall never high.
- MEM_LAT=3: load from 0x20 (preloaded 0x12345678) -> mem_stall high for exactly 2 cycles, WB_ctrl=0 during the stall, then ReadData=0x12345678 and WB_ctrl=2'b11 in the following cycle.
- Mem_Br=1 with Zero=1, then Zero=0 -> PCSrc=1 then 0, same cycle. No stall with MEM_LAT=3.
- MEM_LAT=3: assert rst during cycle 2 of a store of 0xAAAA5555 to 0x40 -> outputs 0, FSM IDLE, later load of 0x40 returns the prior contents.
- DEPTH=256: read_En and write_En both high, DataAddress=0x403, WriteData=7 -> word index 0 written with 7, ReadData=0, misalign pulses 1 cycle.
- ALU op with Mem_WB=2'b10, DataAddress=0x55, dest=9, no memory access -> next cycle ALUResult=0x55, Write_Register=9, RegWrite=1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS pipeline stages
// Purpose: data/register widths, WB control bit positions, MEM-stage FSM states.
// Ports: none (package).
package mips_pkg;
  localparam int DW          = 32;  // data path width
  localparam int RW          = 5;   // register-file address width
  localparam int WB_REGWRITE = 1;   // Mem_WB / WB_ctrl bit: write the register file
  localparam int WB_MEMTOREG = 0;   // Mem_WB / WB_ctrl bit: write-back source is memory

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;
endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - DEPTH x 32 data memory, synchronous write, asynchronous read
// Purpose: word-addressed storage for the MEM stage; contents survive reset.
// Ports:
//   clk     in   write clock, rising edge
//   we_i    in   write enable, sampled at the rising edge
//   addr_i  in   word index, shared by the read and write ports
//   wdata_i in   write data
//   rdata_o out  combinational read of addr_i
module data_mem
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: data-memory access, stall FSM, branch resolve, MEM/WB register
// Purpose: performs the load/store of the instruction in EX/MEM, stretching an access
//   over MEM_LAT cycles with mem_stall, and holds the MEM/WB pipeline register.
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   Mem_WB              WB control from EX/MEM ([1]=RegWrite, [0]=MemtoReg)
//   read_En, write_En   load / store request (both high = store)
//   Mem_Br, Zero        branch-in-MEM flag and ALU zero flag
//   DataAddress         ALU result, used as the byte address
//   WriteData, dest     store data and destination register
//   PCSrc               branch taken, combinational
//   mem_stall           freeze upstream stages while high
//   WB_ctrl, ReadData, ALUResult, Write_Register   MEM/WB register outputs
//   RegWrite            WB_ctrl[1]
//   misalign            one-cycle pulse after an access with DataAddress[1:0] != 0
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    Mem_WB,
  input  logic          read_En,
  input  logic          write_En,
  input  logic          Mem_Br,
  input  logic          Zero,
  input  logic [DW-1:0] DataAddress,
  input  logic [DW-1:0] WriteData,
  input  logic [RW-1:0] dest,
  output logic          PCSrc,
  output logic          mem_stall,
  output logic [1:0]    WB_ctrl,
  output logic [DW-1:0] ReadData,
  output logic [DW-1:0] ALUResult,
  output logic [RW-1:0] Write_Register,
  output logic          RegWrite,
  output logic          misalign
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;
  logic          access, is_load, mem_we;
  logic [DW-1:0] rdata;

  logic [1:0]    wb_ctrl_q;
  logic [DW-1:0] read_data_q, alu_result_q;
  logic [RW-1:0] write_reg_q;
  logic          misalign_q;

  assign access  = read_En | write_En;
  assign is_load = read_En & ~write_En;  // a combined request is treated as a store
  assign PCSrc   = Mem_Br & Zero;

  // With MEM_LAT == 1 the FSM never leaves IDLE and the stage never stalls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && (MEM_LAT > 1)) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // The IDLE stall term is combinational on the inputs, so it must be masked during reset.
  assign mem_stall = stall & ~rst;
  // The array has no reset; an edge seen while rst is high must not commit a store.
  assign mem_we    = write_En & ~mem_stall & ~rst;

  data_mem #(.DEPTH(DEPTH)) u_data_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (DataAddress[AW+1:2]),
    .wdata_i (WriteData),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_ctrl_q    <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (mem_stall) begin
        // Bubble: nothing retires while the access is still in flight.
        wb_ctrl_q   <= '0;
        write_reg_q <= '0;
        misalign_q  <= 1'b0;
      end else begin
        wb_ctrl_q    <= Mem_WB;
        alu_result_q <= DataAddress;
        write_reg_q  <= dest;
        read_data_q  <= is_load ? rdata : '0;
        misalign_q   <= access & (|DataAddress[1:0]);
      end
    end
  end

  assign WB_ctrl        = wb_ctrl_q;
  assign ReadData       = read_data_q;
  assign ALUResult      = alu_result_q;
  assign Write_Register = write_reg_q;
  assign RegWrite       = wb_ctrl_q[WB_REGWRITE];
  assign misalign       = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage at MEM_LAT=1 and MEM_LAT=3
module tb_mem_stage;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  Mem_WB = '0;
  logic        read_En = 1'b0, write_En = 1'b0, Mem_Br = 1'b0, Zero = 1'b0;
  logic [31:0] DataAddress = '0, WriteData = '0;
  logic [4:0]  dest = '0;

  logic        o1_pc, o1_stall, o1_rw, o1_mis, o3_pc, o3_stall, o3_rw, o3_mis;
  logic [1:0]  o1_wb, o3_wb;
  logic [31:0] o1_rd, o1_ra, o3_rd, o3_ra;
  logic [4:0]  o1_wr, o3_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .Mem_WB(Mem_WB), .read_En(read_En), .write_En(write_En),
    .Mem_Br(Mem_Br), .Zero(Zero), .DataAddress(DataAddress), .WriteData(WriteData),
    .dest(dest), .PCSrc(o1_pc), .mem_stall(o1_stall), .WB_ctrl(o1_wb), .ReadData(o1_rd),
    .ALUResult(o1_ra), .Write_Register(o1_wr), .RegWrite(o1_rw), .misalign(o1_mis)
  );

  mem_stage #(.DEPTH(256), .MEM_LAT(LAT3)) u_lat3 (
    .clk(clk), .rst(rst), .Mem_WB(Mem_WB), .read_En(read_En), .write_En(write_En),
    .Mem_Br(Mem_Br), .Zero(Zero), .DataAddress(DataAddress), .WriteData(WriteData),
    .dest(dest), .PCSrc(o3_pc), .mem_stall(o3_stall), .WB_ctrl(o3_wb), .ReadData(o3_rd),
    .ALUResult(o3_ra), .Write_Register(o3_wr), .RegWrite(o3_rw), .misalign(o3_mis)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] ra;
    logic [4:0]  wr;
    logic        mis;
  } wbreg_t;

  wbreg_t      e1 = '0, e3 = '0;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  int          age = 0;      // cycles the current access has already spent in the LAT3 stage
  bit          m3_done = 1'b0;

  function automatic wbreg_t retire(input logic [31:0] ld_data);
    wbreg_t r;
    r.wb  = Mem_WB;
    r.ra  = DataAddress;
    r.wr  = dest;
    r.rd  = (read_En && !write_En) ? ld_data : 32'h0;
    r.mis = (read_En || write_En) && (DataAddress[1:0] != 2'b00);
    return r;
  endfunction

  function automatic logic exp_stall3();
    return !rst && (read_En || write_En) && (age < LAT3 - 1);
  endfunction

  always @(posedge clk) begin
    logic [7:0] w;
    w = DataAddress[9:2];
    if (rst) begin
      e1 = '0; e3 = '0; age = 0; m3_done = 1'b0;
    end else begin
      e1 = retire(mem1[w]);
      if (write_En) mem1[w] = WriteData;
      if ((read_En || write_En) && age < LAT3 - 1) begin
        e3.wb = 2'b00; e3.wr = 5'd0; e3.mis = 1'b0;
        age++;
        m3_done = 1'b0;
      end else begin
        e3 = retire(mem3[w]);
        if (write_En) mem3[w] = WriteData;
        age = 0;
        m3_done = 1'b1;
      end
    end
  end

  // ---------------- comparison ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string t, input wbreg_t e, input logic est, input logic pc,
                     input logic st, input logic [1:0] wb, input logic [31:0] rd,
                     input logic [31:0] ra, input logic [4:0] wr, input logic rw,
                     input logic mis);
    chk({t, " PCSrc"}, pc, Mem_Br & Zero);
    chk({t, " mem_stall"}, st, est);
    chk({t, " WB_ctrl"}, wb, e.wb);
    chk({t, " ReadData"}, rd, e.rd);
    chk({t, " ALUResult"}, ra, e.ra);
    chk({t, " Write_Register"}, wr, e.wr);
    chk({t, " RegWrite"}, rw, e.wb[1]);
    chk({t, " misalign"}, mis, e.mis);
  endtask

  always @(negedge clk) begin
    cmp("lat1", rst ? wbreg_t'(0) : e1, 1'b0, o1_pc, o1_stall, o1_wb, o1_rd, o1_ra, o1_wr,
        o1_rw, o1_mis);
    cmp("lat3", rst ? wbreg_t'(0) : e3, exp_stall3(), o3_pc, o3_stall, o3_wb, o3_rd, o3_ra,
        o3_wr, o3_rw, o3_mis);
  end

  // Upstream must hold EX/MEM steady across every stalled edge.
  assert property (@(posedge clk) disable iff (rst)
      o3_stall |=> $stable({Mem_WB, read_En, write_En, Mem_Br, Zero, DataAddress, WriteData, dest}))
    else begin
      errors++;
      $display("FAIL stall_hold: EX/MEM inputs changed while mem_stall was high at %0t", $time);
    end

  // ---------------- stimulus ----------------
  // Presents one instruction (caller is just after a rising edge) and holds it until the
  // LAT3 stage retires it; returns the number of stalled cycles seen on that instance.
  task automatic run_instr(input logic [1:0] wb, input logic re, input logic we,
                           input logic br, input logic z, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] d, output int stalls);
    bit done;
    Mem_WB = wb; read_En = re; write_En = we; Mem_Br = br; Zero = z;
    DataAddress = addr; WriteData = wd; dest = d;
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (o3_stall) stalls++;
      @(posedge clk);
      #1;
      done = m3_done;
    end
    if (!done) begin
      errors++;
      $display("FAIL run_instr timeout: got no completion expected completion within 10 cycles");
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 8)  return 32'h1234_5678;
    if (i == 16) return 32'h0BAD_F00D;
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    int          s;
    int          r;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("reset WB_ctrl", o3_wb, 32'h0);
    chk("reset ReadData", o3_rd, 32'h0);
    chk("reset mem_stall", o3_stall, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) run_instr(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 4), init_val(i), 5'd0, s);

    // store then load at latency 1
    run_instr(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0, s);
    run_instr(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, s);
    chk("lat1 load ReadData", o1_rd, 32'hDEAD_BEEF);
    chk("lat1 load Write_Register", o1_wr, 32'd5);
    chk("lat1 load RegWrite", o1_rw, 32'd1);

    // load with latency 3
    run_instr(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 5'd7, s);
    chk("lat3 stall cycles", s, 32'd2);
    chk("lat3 load ReadData", o3_rd, 32'h1234_5678);
    chk("lat3 load WB_ctrl", o3_wb, 32'h3);

    // branch resolution, no stall
    run_instr(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd0, s);
    chk("branch stall cycles", s, 32'd0);
    Mem_Br = 1'b1; Zero = 1'b1; #1;
    chk("PCSrc taken", o3_pc, 32'd1);
    Zero = 1'b0; #1;
    chk("PCSrc not taken", o3_pc, 32'd0);
    chk("branch mem_stall", o3_stall, 32'd0);
    @(posedge clk); #1;
    Mem_Br = 1'b0;

    // reset during the second cycle of a store
    Mem_WB = 2'b00; read_En = 1'b0; write_En = 1'b1; DataAddress = 32'h40; WriteData = 32'hAAAA_5555;
    @(posedge clk); #3;
    rst = 1'b1; write_En = 1'b0; DataAddress = 32'h0; WriteData = 32'h0;
    #1;
    chk("mid-busy reset mem_stall", o3_stall, 32'd0);
    chk("mid-busy reset ALUResult", o3_ra, 32'h0);
    chk("mid-busy reset WB_ctrl", o3_wb, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 5'd3, s);
    chk("lat3 discarded store", o3_rd, 32'h0BAD_F00D);
    chk("lat1 committed store", o1_rd, 32'hAAAA_5555);

    // combined request, unaligned, wraps to word 0
    run_instr(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h403, 32'd7, 5'd0, s);
    chk("combined ReadData", o3_rd, 32'h0);
    chk("combined misalign", o3_mis, 32'd1);
    run_instr(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, s);
    chk("misalign pulse end", o3_mis, 32'd0);
    run_instr(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd1, s);
    chk("word 0 after wrap store", o3_rd, 32'd7);

    // ALU pass-through
    run_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9, s);
    chk("alu stall cycles", s, 32'd0);
    chk("alu ALUResult", o3_ra, 32'h55);
    chk("alu Write_Register", o3_wr, 32'd9);
    chk("alu RegWrite", o3_rw, 32'd1);

    // randomized traffic over the initialised words, with random wrap bits
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run_instr(2'($urandom), (r <= 2) || (r == 6), (r >= 3) && (r <= 6),
                1'($urandom), 1'($urandom), a, $urandom, 5'($urandom), s);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
